// File: rtl/addsub_pkg.sv
// Shared types and helpers for the slice-serial adder-subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_W = 128;

  // Signed max (0111..1) or min (100..0) for the given width, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_bound(input int width, input logic want_min);
    logic [MAX_W-1:0] r;
    r = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width - 1) begin
        r[i] = ~want_min;
      end else if (i == width - 1) begin
        r[i] = want_min;
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit ripple of full adders; also exposes the carry into the top bit.
module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [SLICE:0] c_s;

  // Full-adder ripple across the slice.
  always_comb begin
    c_s    = {(SLICE+1){1'b0}};
    sum    = {SLICE{1'b0}};
    c_s[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (a[i] & c_s[i]) | (b[i] & c_s[i]);
    end
    cout = c_s[SLICE];
    cmsb = c_s[SLICE-1];
  end

endmodule

// File: rtl/addsub_serial.sv
// Slice-serial adder-subtractor with valid/ready handshake and carry/ovf/zero/neg flags.
// Optional build macro ADDSUB_SAT_EN clamps s to signed max/min on overflow.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_r, b_r, s_r;
  logic             sub_r, carry_r;
  logic [IDXW-1:0]  idx_r;
  logic             in_ready_r, out_valid_r;
  logic             cout_r, ovf_r, zero_r, neg_r;

  logic [SLICE-1:0] a_sl_s, b_sl_s, sum_s;
  logic             sl_cout_s, sl_cmsb_s, ovf_s;
  logic [WIDTH-1:0] s_next_s, s_fin_s;

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_sl_s),
    .b    (b_sl_s),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (sl_cout_s),
    .cmsb (sl_cmsb_s)
  );

  // Select the active slice and merge its sum into the running result.
  always_comb begin
    a_sl_s   = a_r[32'(idx_r) * SLICE +: SLICE];
    b_sl_s   = b_r[32'(idx_r) * SLICE +: SLICE];
    s_next_s = s_r;
    s_next_s[32'(idx_r) * SLICE +: SLICE] = sum_s;
    ovf_s    = sl_cmsb_s ^ sl_cout_s;
`ifdef ADDSUB_SAT_EN
    // On overflow the true sign is the opposite of the wrapped MSB.
    if (ovf_s) begin
      s_fin_s = WIDTH'(sat_bound(WIDTH, ~s_next_s[WIDTH-1]));
    end else begin
      s_fin_s = s_next_s;
    end
`else
    s_fin_s = s_next_s;
`endif
  end

  // Control FSM with registered handshake outputs and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      s_r         <= {WIDTH{1'b0}};
      sub_r       <= 1'b0;
      carry_r     <= 1'b0;
      idx_r       <= {IDXW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b ^ {WIDTH{sub}};
            sub_r      <= sub;
            carry_r    <= sub;
            idx_r      <= {IDXW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          carry_r <= sl_cout_s;
          if (idx_r == LAST) begin
            s_r         <= s_fin_s;
            cout_r      <= sl_cout_s ^ sub_r;
            ovf_r       <= ovf_s;
            zero_r      <= (s_fin_s == {WIDTH{1'b0}});
            neg_r       <= s_fin_s[WIDTH-1];
            idx_r       <= {IDXW{1'b0}};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            s_r   <= s_next_s;
            idx_r <= idx_r + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;
  assign neg       = neg_r;

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, slice-serial signed/unsigned adder-subtractor with a valid/ready handshake. It processes a WIDTH-bit operation in WIDTH/SLICE clock cycles, rippling one SLICE-bit chunk per cycle through a registered carry. It reports carry/borrow, signed overflow, zero and negative flags. It is the datapath arithmetic unit for wide operands where a full-width ripple chain would not meet timing.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SLICE, ≥2
- SLICE, 4, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  unit can accept; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: s=a+b; 1: s=a-b (a + ~b + 1)
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  result
- cout  out  1  add: carry out of MSB; sub: borrow (inverted MSB carry)
- ovf  out  1  signed overflow
- zero  out  1  s == 0
- neg  out  1  s[WIDTH-1]

## Operation
- N = WIDTH/SLICE. FSM states IDLE, RUN, DONE.
- Reset: state IDLE; in_ready=1 on the first cycle after reset; out_valid=0; s, cout, ovf, zero, neg = 0; slice index and carry register = 0.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b (b inverted when sub=1) and sub. Set carry = sub and index = 0. Go to RUN.
- RUN: in_ready=0. Each cycle, slice k = index adds a[k], b'[k] and carry, writes s[k] and updates carry. After slice N-1: compute flags, go to DONE.
- Input changes during RUN/DONE are ignored; the latched operands are used.
- Flags:
  - ovf = carry into MSB XOR carry out of MSB.
  - cout = final carry XOR sub.
  - zero and neg are derived from the final s.
- DONE: out_valid=1. s and flags are stable until out_valid&out_ready, then IDLE next cycle.
- Synchronous rst in any state aborts the operation and restores all reset values on the next edge.
- SLICE == WIDTH: N=1; RUN lasts one cycle.

## Timing
- Accept at cycle 0 edge. RUN occupies cycles 1..N. out_valid first asserts in cycle N+1.
- With out_ready held high, the result transfers in cycle N+1; in_ready=1 in cycle N+2. Throughput is one op per N+2 cycles.
- out_ready is ignored when out_valid=0. in_valid is ignored when in_ready=0.
- in_ready and out_valid are registered state decodes and never high simultaneously.
- There is no combinational path from in_valid/out_ready to any output.

## Configuration
- ADDSUB_SAT_EN defined: on ovf=1, s is clamped to signed max (0111…1) if the true result is positive, or signed min (100…0) if negative. ovf is still reported as 1. cout is unchanged. zero and neg are computed from the clamped s. The clamp is applied in the same cycle as flag computation, with no added latency.
- Not defined: s wraps modulo 2^WIDTH; no clamp logic.

## Structure
- Shared package addsub_pkg: FSM state enum (IDLE, RUN, DONE). Also a function returning signed max/min for a given width.
- Sub-module addsub_slice: combinational SLICE-bit ripple of full adders (inputs a, b', cin; outputs sum, cout, and carry into top bit for ovf). One instance, reused across cycles via the index.

## Test plan
WIDTH=16, SLICE=4 (N=4) unless stated.
- Add 0x1234 + 0x0FFF → s=0x2233, cout=0, ovf=0, zero=0, neg=0; out_valid in cycle 5 after accept.
- Sub 0x0005 − 0x0007 → s=0xFFFE, cout=1 (borrow), neg=1, ovf=0.
- Signed overflow:
  - 0x7FFF + 0x0001 → ovf=1; s=0x8000 without macro, 0x7FFF with ADDSUB_SAT_EN.
  - Sub 0x8000 − 0x0001 → ovf=1; s=0x7FFF without macro, 0x8000 with it.
- Sub 0x0000 − 0x0000 → s=0, zero=1, cout=0. Add 0xFFFF + 0x0001 → s=0, cout=1, zero=1, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles and toggle a/b/in_valid during RUN and DONE. s and flags stay stable, in_ready stays 0, and the result matches the originally latched operands.
- Assert rst in RUN at slice 2. Next cycle: in_ready=1, out_valid=0, s=0. A fresh op then completes correctly. Repeat all cases with SLICE=1 and SLICE=16.
